// File: rtl/linecoding_pkg.sv
// Shared 8b/10b line-coding constants and aligner state type.
// Used by encoder_8b10b, decoder_10b8b and symbol_aligner_10b.
package linecoding_pkg;

    localparam int SYM_W = 10;

    localparam logic [SYM_W-1:0] K28_5_RDN = 10'h0FA;
    localparam logic [SYM_W-1:0] K28_5_RDP = 10'h305;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } align_state_e;

endpackage

// File: rtl/comma_detect_10b.sv
// Combinational K28.5 detector on a 10-bit symbol {a..j} = [9:0].
// rd_pos flags the RD+ form of the comma.
module comma_detect_10b
    import linecoding_pkg::*;
(
    input  logic [SYM_W-1:0] sym,
    output logic             is_comma,
    output logic             rd_pos
);

    assign rd_pos   = (sym == K28_5_RDP);
    assign is_comma = (sym == K28_5_RDN) || rd_pos;

endmodule

// File: rtl/symbol_aligner_10b.sv
// Serial comma aligner: hunts K28.5, verifies phase, emits aligned symbols.
// ALIGNER_STATS_EN adds a saturating realign_cnt output.
module symbol_aligner_10b
    import linecoding_pkg::*;
#(
    parameter int LOCK_COMMAS = 3,
    parameter int UNLOCK_ERRS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [SYM_W-1:0] sym_out,
    output logic             sym_valid,
    output logic             sym_is_comma,
    output logic             locked
`ifdef ALIGNER_STATS_EN
    ,
    output logic [15:0]      realign_cnt
`endif
);

    localparam int CW = $clog2(LOCK_COMMAS + 1);
    localparam int EW = $clog2(UNLOCK_ERRS + 1);

    align_state_e     state_q, state_d;
    logic [8:0]       sr_q, sr_d;
    logic [3:0]       bit_q, bit_d;
    logic [CW-1:0]    cc_q, cc_d;
    logic [EW-1:0]    ec_q, ec_d;
    logic [SYM_W-1:0] sym_q, sym_d;
    logic             symc_q, symc_d;
    logic             symv_q, symv_d;

    logic [SYM_W-1:0] sr_nxt;
    logic             det_comma;
    logic             det_rdp;
    logic             comma;
    logic             boundary;
    logic             lock_last;
    logic             miss_last;

    // Only 9 bits of history are kept; the 10th is the incoming line bit.
    assign sr_nxt    = {sr_q, sin};
    assign comma     = det_comma | det_rdp;
    assign boundary  = (bit_q == 4'd9);
    assign lock_last = (cc_q == CW'(LOCK_COMMAS - 1));
    assign miss_last = (ec_q == EW'(UNLOCK_ERRS - 1));

    comma_detect_10b u_det (
        .sym      (sr_nxt),
        .is_comma (det_comma),
        .rd_pos   (det_rdp)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        cc_d    = cc_q;
        ec_d    = ec_q;
        sym_d   = sym_q;
        symc_d  = symc_q;
        symv_d  = 1'b0;
        if (sin_valid) begin
            sr_d  = sr_nxt[8:0];
            bit_d = boundary ? 4'd0 : bit_q + 4'd1;
            unique case (state_q)
                HUNT: begin
                    if (comma) begin
                        bit_d   = 4'd0;
                        cc_d    = CW'(1);
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (comma && boundary) begin
                        if (cc_q != CW'(LOCK_COMMAS)) cc_d = cc_q + 1'b1;
                        if (lock_last) state_d = LOCKED;
                    end else if (comma) begin
                        bit_d = 4'd0;
                        cc_d  = CW'(1);
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        sym_d  = sr_nxt;
                        symc_d = comma;
                        symv_d = 1'b1;
                    end
                    // A comma on the boundary is aligned by definition.
                    if (comma && boundary) begin
                        ec_d = '0;
                    end else if (comma && miss_last) begin
                        state_d = HUNT;
                        bit_d   = 4'd0;
                        cc_d    = '0;
                        ec_d    = '0;
                    end else if (comma) begin
                        if (ec_q != EW'(UNLOCK_ERRS)) ec_d = ec_q + 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= HUNT;
            sr_q    <= '0;
            bit_q   <= '0;
            cc_q    <= '0;
            ec_q    <= '0;
            sym_q   <= '0;
            symc_q  <= 1'b0;
            symv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            cc_q    <= cc_d;
            ec_q    <= ec_d;
            sym_q   <= sym_d;
            symc_q  <= symc_d;
            symv_q  <= symv_d;
        end
    end

    assign sym_out      = sym_q;
    assign sym_valid    = symv_q;
    assign sym_is_comma = symc_q;
    assign locked       = (state_q == LOCKED);

`ifdef ALIGNER_STATS_EN
    logic        realign;
    logic [15:0] rc_q, rc_d;

    // Counts VERIFY realigns and LOCKED->HUNT drops.
    assign realign = sin_valid && comma && !boundary &&
                     ((state_q == VERIFY) ||
                      (state_q == LOCKED && miss_last));

    always_comb begin
        rc_d = rc_q;
        if (realign && rc_q != 16'hFFFF) rc_d = rc_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) rc_q <= '0;
        else      rc_q <= rc_d;
    end

    assign realign_cnt = rc_q;
`endif

endmodule
